// File: rtl/rast_params_pkg.sv
// Shared rasteriser geometry defaults and element types, common to the polygon FIFO
// and the dff2/dff3 pipeline stages.
package rast_params_pkg;

  localparam int SIGFIG = 24;
  localparam int VERTS  = 3;
  localparam int AXIS   = 3;
  localparam int COLORS = 3;

  typedef logic [SIGFIG-1:0]   coord_t;
  typedef coord_t [AXIS-1:0]   vertex_t;
  typedef coord_t [COLORS-1:0] color_t;

  // Flattened width of one stored polygon (all vertex coordinates followed by colour).
  function automatic int entry_bits(int sigfig, int verts, int axis, int colors);
    return sigfig * (verts * axis + colors);
  endfunction

endpackage

// File: rtl/poly_fifo_if.sv
// Polygon stream interface around poly_fifo: upstream push side, downstream head side
// and occupancy. slave = FIFO side, master = producer/consumer side.
interface poly_fifo_if #(
  parameter int SIGFIG = rast_params_pkg::SIGFIG,
  parameter int VERTS  = rast_params_pkg::VERTS,
  parameter int AXIS   = rast_params_pkg::AXIS,
  parameter int COLORS = rast_params_pkg::COLORS,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [SIGFIG-1:0] poly_in  [VERTS][AXIS];
  logic [SIGFIG-1:0] color_in [COLORS];
  logic              validPoly_in;
  logic              halt_out;
  logic [SIGFIG-1:0] poly_out  [VERTS][AXIS];
  logic [SIGFIG-1:0] color_out [COLORS];
  logic              validPoly_out;
  logic              halt_in;
  logic [CNT_W-1:0]  count_out;

  modport slave (
    input  poly_in, color_in, validPoly_in, halt_in,
    output halt_out, poly_out, color_out, validPoly_out, count_out
  );

  modport master (
    output poly_in, color_in, validPoly_in, halt_in,
    input  halt_out, poly_out, color_out, validPoly_out, count_out
  );
endinterface

// File: rtl/poly_fifo_ctrl.sv
// Pointer/occupancy control for poly_fifo: push/pop decisions, halt_out and validPoly_out.
// POLY_FIFO_BYPASS_EN adds the empty-FIFO pass-through decision.
module poly_fifo_ctrl #(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             validPoly_in,
  input  logic             halt_in,
  output logic             push,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [PTR_W-1:0] rd_idx,
  output logic [CNT_W-1:0] count,
`ifdef POLY_FIFO_BYPASS_EN
  output logic             bypass,
`endif
  output logic             halt_out,
  output logic             validPoly_out
);

  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             stored;
  logic             pop;
  logic             bypass_hit;

  always_comb begin
    stored   = (count_reg != '0);
    halt_out = (count_reg == CNT_W'(DEPTH));
`ifdef POLY_FIFO_BYPASS_EN
    // Held low during reset so validPoly_out stays 0 while reset is asserted.
    bypass_hit = reset && !stored && validPoly_in && !halt_in;
`else
    bypass_hit = 1'b0;
`endif
    push          = validPoly_in && !halt_out && !bypass_hit;
    pop           = stored && !halt_in;
    validPoly_out = stored || bypass_hit;

    wr_ptr_next = push ? wr_ptr_reg + 1'b1 : wr_ptr_reg;
    rd_ptr_next = pop  ? rd_ptr_reg + 1'b1 : rd_ptr_reg;
    count_next  = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase

    // When empty, the slot just behind rd_ptr still holds the last popped entry.
    rd_idx = stored ? rd_ptr_reg : rd_ptr_reg - 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  assign wr_ptr = wr_ptr_reg;
  assign count  = count_reg;
`ifdef POLY_FIFO_BYPASS_EN
  assign bypass = bypass_hit;
`endif

endmodule

// File: rtl/poly_fifo.sv
// Polygon FIFO between rasteriser stages: storage and output muxing around poly_fifo_ctrl.
// Optional POLY_FIFO_BYPASS_EN gives a zero-latency pass-through when the FIFO is empty.
module poly_fifo #(
  parameter int SIGFIG = rast_params_pkg::SIGFIG,
  parameter int VERTS  = rast_params_pkg::VERTS,
  parameter int AXIS   = rast_params_pkg::AXIS,
  parameter int COLORS = rast_params_pkg::COLORS,
  parameter int DEPTH  = 4
) (
  input logic        clk,
  input logic        reset,
  poly_fifo_if.slave bus
);
  import rast_params_pkg::*;

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int POLY_W  = SIGFIG * VERTS * AXIS;
  localparam int ENTRY_W = entry_bits(SIGFIG, VERTS, AXIS, COLORS);

  logic               push;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_idx;
  logic [ENTRY_W-1:0] wr_data;
  logic [ENTRY_W-1:0] head_data;
  logic [ENTRY_W-1:0] out_data;
  logic [ENTRY_W-1:0] mem_reg [DEPTH];
`ifdef POLY_FIFO_BYPASS_EN
  logic               bypass;
`endif

  poly_fifo_ctrl #(.DEPTH(DEPTH)) u_ctrl (
    .clk           (clk),
    .reset         (reset),
    .validPoly_in  (bus.validPoly_in),
    .halt_in       (bus.halt_in),
    .push          (push),
    .wr_ptr        (wr_ptr),
    .rd_idx        (rd_idx),
    .count         (bus.count_out),
`ifdef POLY_FIFO_BYPASS_EN
    .bypass        (bypass),
`endif
    .halt_out      (bus.halt_out),
    .validPoly_out (bus.validPoly_out)
  );

  // Entry layout: vertex coordinates (vertex-major) in the low bits, colour above them.
  for (genvar gi = 0; gi < VERTS; gi++) begin : g_vert
    for (genvar gj = 0; gj < AXIS; gj++) begin : g_axis
      localparam int OFS = (gi * AXIS + gj) * SIGFIG;
      assign wr_data[OFS +: SIGFIG] = bus.poly_in[gi][gj];
      assign bus.poly_out[gi][gj]   = out_data[OFS +: SIGFIG];
    end
  end

  for (genvar gi = 0; gi < COLORS; gi++) begin : g_color
    localparam int OFS = POLY_W + gi * SIGFIG;
    assign wr_data[OFS +: SIGFIG] = bus.color_in[gi];
    assign bus.color_out[gi]      = out_data[OFS +: SIGFIG];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else if (push) begin
      mem_reg[wr_ptr] <= wr_data;
    end
  end

  assign head_data = mem_reg[rd_idx];

`ifdef POLY_FIFO_BYPASS_EN
  assign out_data = bypass ? wr_data : head_data;
`else
  assign out_data = head_data;
`endif

endmodule

// File: tb/tb_poly_fifo.sv
// Directed bench for poly_fifo: table of per-cycle vectors for fill/drain/full corners,
// plus hand sequences for a halt-toggled stream and mid-operation reset.
module tb_poly_fifo;
  import rast_params_pkg::*;

  localparam int DEPTH   = 4;
  localparam int POLY_W  = SIGFIG * VERTS * AXIS;
  localparam int ENTRY_W = entry_bits(SIGFIG, VERTS, AXIS, COLORS);

  typedef struct {
    bit valid_in;
    int tag_in;
    bit halt_in;
    bit exp_valid;
    int exp_tag;
    int exp_count;
    bit exp_halt;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  poly_fifo_if #(.DEPTH(DEPTH)) bus ();

  poly_fifo #(
    .SIGFIG (SIGFIG),
    .VERTS  (VERTS),
    .AXIS   (AXIS),
    .COLORS (COLORS),
    .DEPTH  (DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Tag 0 is the all-zero entry; other tags give a distinct value per coordinate.
  function automatic logic [ENTRY_W-1:0] make_entry(int tag);
    logic [ENTRY_W-1:0] e;
    e = '0;
    if (tag != 0) begin
      for (int v = 0; v < VERTS; v++)
        for (int a = 0; a < AXIS; a++)
          e[(v * AXIS + a) * SIGFIG +: SIGFIG] = {8'(tag), 8'(v), 8'(a)};
      for (int c = 0; c < COLORS; c++)
        e[POLY_W + c * SIGFIG +: SIGFIG] = {8'(tag), 8'hC0, 8'(c)};
    end
    return e;
  endfunction

  function automatic logic [ENTRY_W-1:0] pack_out();
    logic [ENTRY_W-1:0] e;
    e = '0;
    for (int v = 0; v < VERTS; v++)
      for (int a = 0; a < AXIS; a++)
        e[(v * AXIS + a) * SIGFIG +: SIGFIG] = bus.poly_out[v][a];
    for (int c = 0; c < COLORS; c++)
      e[POLY_W + c * SIGFIG +: SIGFIG] = bus.color_out[c];
    return e;
  endfunction

  task automatic set_in(int tag, bit valid);
    logic [ENTRY_W-1:0] e;
    e = make_entry(tag);
    bus.validPoly_in = valid;
    for (int v = 0; v < VERTS; v++)
      for (int a = 0; a < AXIS; a++)
        bus.poly_in[v][a] = e[(v * AXIS + a) * SIGFIG +: SIGFIG];
    for (int c = 0; c < COLORS; c++)
      bus.color_in[c] = e[POLY_W + c * SIGFIG +: SIGFIG];
  endtask

  task automatic chk_int(string name, int got, int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic chk_data(string name, int exp_tag);
    logic [ENTRY_W-1:0] got;
    logic [ENTRY_W-1:0] exp;
    got = pack_out();
    exp = make_entry(exp_tag);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (tag %0d)", name, got, exp, exp_tag);
    end
  endtask

  task automatic chk_state(string name, bit valid, int count, bit halt);
    chk_int({name, "_valid"}, int'(bus.validPoly_out), int'(valid));
    chk_int({name, "_count"}, int'(bus.count_out), count);
    chk_int({name, "_halt"}, int'(bus.halt_out), int'(halt));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  next_tag;
    int  rx;
    int  budget;
    bit  halt;
    bit  acc;

    // Fill A..D under downstream stall, hold E, drain; then full-with-pop corner using F..J.
    tbl.push_back('{1, 1, 1, 0, 0, 0, 0});
    tbl.push_back('{1, 2, 1, 1, 1, 1, 0});
    tbl.push_back('{1, 3, 1, 1, 1, 2, 0});
    tbl.push_back('{1, 4, 1, 1, 1, 3, 0});
    tbl.push_back('{1, 5, 1, 1, 1, 4, 1});
    tbl.push_back('{1, 5, 1, 1, 1, 4, 1});
    tbl.push_back('{0, 0, 0, 1, 1, 4, 1});
    tbl.push_back('{0, 0, 0, 1, 2, 3, 0});
    tbl.push_back('{0, 0, 0, 1, 3, 2, 0});
    tbl.push_back('{0, 0, 0, 1, 4, 1, 0});
    tbl.push_back('{0, 0, 1, 0, 4, 0, 0});
    tbl.push_back('{1, 6, 1, 0, 4, 0, 0});
    tbl.push_back('{1, 7, 1, 1, 6, 1, 0});
    tbl.push_back('{1, 8, 1, 1, 6, 2, 0});
    tbl.push_back('{1, 9, 1, 1, 6, 3, 0});
    tbl.push_back('{1, 10, 0, 1, 6, 4, 1});
    tbl.push_back('{1, 10, 1, 1, 7, 3, 0});
    tbl.push_back('{0, 0, 1, 1, 7, 4, 1});
    tbl.push_back('{0, 0, 0, 1, 7, 4, 1});
    tbl.push_back('{0, 0, 0, 1, 8, 3, 0});
    tbl.push_back('{0, 0, 0, 1, 9, 2, 0});
    tbl.push_back('{0, 0, 0, 1, 10, 1, 0});
    tbl.push_back('{0, 0, 1, 0, 10, 0, 0});

    reset = 1'b0;
    bus.halt_in = 1'b1;
    set_in(0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_state("reset", 1'b0, 0, 1'b0);
    chk_data("reset_data", 0);
    $display("[TB] reset: count=%0d valid=%0b halt=%0b", bus.count_out, bus.validPoly_out, bus.halt_out);
    reset = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < tbl.size(); i++) begin
      set_in(tbl[i].tag_in, tbl[i].valid_in);
      bus.halt_in = tbl[i].halt_in;
      @(negedge clk);
      $display("[TB] vec %0d: in_tag=%0d v=%0b halt_in=%0b -> count=%0d valid=%0b halt=%0b",
               i, tbl[i].tag_in, tbl[i].valid_in, tbl[i].halt_in,
               bus.count_out, bus.validPoly_out, bus.halt_out);
      chk_state($sformatf("vec%0d", i), tbl[i].exp_valid, tbl[i].exp_count, tbl[i].exp_halt);
      chk_data($sformatf("vec%0d_data", i), tbl[i].exp_tag);
      @(posedge clk);
      #1;
    end

    // Ten-poly stream with halt_in toggling each cycle; pushes taken whenever halt_out is low.
    next_tag = 20;
    rx       = 0;
    budget   = 0;
    halt     = 1'b0;
    while (rx < 10 && budget < 200) begin
      bus.halt_in = halt;
      if (next_tag < 30) set_in(next_tag, 1'b1);
      else               set_in(0, 1'b0);
      @(negedge clk);
      acc = bus.validPoly_in && !bus.halt_out;
      if (bus.validPoly_out && !bus.halt_in) begin
        $display("[TB] stream pop %0d: count=%0d", rx, bus.count_out);
        chk_data($sformatf("stream%0d", rx), 20 + rx);
        rx++;
      end
      @(posedge clk);
      #1;
      if (acc) next_tag++;
      halt = !halt;
      budget++;
    end
    chk_int("stream_received", rx, 10);
    chk_int("stream_pushed", next_tag, 30);

    // Load three entries, then reset mid-operation.
    bus.halt_in = 1'b1;
    for (int t = 40; t < 43; t++) begin
      set_in(t, 1'b1);
      @(posedge clk);
      #1;
    end
    set_in(0, 1'b0);
    @(negedge clk);
    chk_int("pre_reset_count", int'(bus.count_out), 3);
    reset = 1'b0;
    #1;
    $display("[TB] mid reset: count=%0d valid=%0b", bus.count_out, bus.validPoly_out);
    chk_state("midreset", 1'b0, 0, 1'b0);
    chk_data("midreset_data", 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    set_in(43, 1'b1);
    #1;
    chk_int("post_reset_same_cycle_valid", int'(bus.validPoly_out), 0);
    @(posedge clk);
    #1;
    set_in(0, 1'b0);
    @(negedge clk);
    $display("[TB] first push after reset: count=%0d valid=%0b", bus.count_out, bus.validPoly_out);
    chk_state("post_reset_push", 1'b1, 1, 1'b0);
    chk_data("post_reset_data", 43);
    bus.halt_in = 1'b0;
    @(posedge clk);
    #1;

    // Push into an empty FIFO with downstream ready: latency depends on the bypass build.
    set_in(44, 1'b1);
    @(negedge clk);
    $display("[TB] empty push, halt_in=0: count=%0d valid=%0b", bus.count_out, bus.validPoly_out);
`ifdef POLY_FIFO_BYPASS_EN
    chk_state("bypass_same", 1'b1, 0, 1'b0);
    chk_data("bypass_same_data", 44);
`else
    chk_state("nobypass_same", 1'b0, 0, 1'b0);
    chk_data("nobypass_same_data", 43);
`endif
    @(posedge clk);
    #1;
    set_in(0, 1'b0);
    bus.halt_in = 1'b1;
    @(negedge clk);
`ifdef POLY_FIFO_BYPASS_EN
    chk_state("bypass_next", 1'b0, 0, 1'b0);
`else
    chk_state("nobypass_next", 1'b1, 1, 1'b0);
    chk_data("nobypass_next_data", 44);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
